// File: rtl/core_bus_arbiter.sv
// Two-into-one Wishbone arbiter. It connects the instruction-fetch port and the
// data-memory port to one shared bus. The grant is held until the transaction
// completes. A watchdog turns a hung slave into an error response.
module core_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          DATA_PRIORITY  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // instruction port
    input  logic        iwbs_cyc_i,
    input  logic        iwbs_stb_i,
    input  logic [31:0] iwbs_addr_i,
    output logic [31:0] iwbs_dat_o,
    output logic        iwbs_ack_o,
    output logic        iwbs_err_o,
    // data port
    input  logic        dwbs_cyc_i,
    input  logic        dwbs_stb_i,
    input  logic        dwbs_we_i,
    input  logic [3:0]  dwbs_sel_i,
    input  logic [31:0] dwbs_addr_i,
    input  logic [31:0] dwbs_dat_i,
    output logic [31:0] dwbs_dat_o,
    output logic        dwbs_ack_o,
    output logic        dwbs_err_o,
    // shared bus
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    // A disabled watchdog still gets a 1-bit counter so no zero-width vectors appear.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit            WdEn    = (TIMEOUT_CYCLES != 0);
    localparam logic [CntW-1:0] CntMax  = '1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

    state_e          state_q, state_d;
    logic            last_gnt_q, last_gnt_d;  // 1 = data port was granted last
    logic [CntW-1:0] cnt_q, cnt_d;

    logic i_req, d_req, resp, gnt_cyc, timeout;

    assign i_req = iwbs_cyc_i & iwbs_stb_i;
    assign d_req = dwbs_cyc_i & dwbs_stb_i;
    assign resp  = wbm_ack_i | wbm_err_i;

    // Read data is broadcast; only ack/err are steered.
    assign iwbs_dat_o = wbm_dat_i;
    assign dwbs_dat_o = wbm_dat_i;

    // Cycle line of the currently granted port; low means abort or no grant.
    always_comb begin
        gnt_cyc = 1'b0;
        case (state_q)
            StGntI:  gnt_cyc = iwbs_cyc_i;
            StGntD:  gnt_cyc = dwbs_cyc_i;
            default: gnt_cyc = 1'b0;
        endcase
    end

    // Watchdog fires on the last allowed wait cycle unless the slave responds then.
    assign timeout = WdEn && (state_q != StIdle) && gnt_cyc && !resp && (cnt_q == CntLast);

    // State, grant history and watchdog registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
        end
    end

    // Arbitration and transaction-completion next state.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (d_req && (!i_req || DATA_PRIORITY || !last_gnt_q)) begin
                    state_d    = StGntD;
                    last_gnt_d = 1'b1;
                end else if (i_req) begin
                    state_d    = StGntI;
                    last_gnt_d = 1'b0;
                end
            end
            StGntI, StGntD: begin
                if (!gnt_cyc || resp || timeout) begin
                    state_d = StIdle;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus request muxing and response steering.
    always_comb begin
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_sel_o  = 4'h0;
        wbm_addr_o = 32'h0;
        wbm_dat_o  = 32'h0;
        iwbs_ack_o = 1'b0;
        iwbs_err_o = 1'b0;
        dwbs_ack_o = 1'b0;
        dwbs_err_o = 1'b0;
        case (state_q)
            StGntI: begin
                wbm_cyc_o  = i_req & ~timeout;
                wbm_stb_o  = i_req;
                wbm_sel_o  = 4'hF;
                wbm_addr_o = iwbs_addr_i;
                iwbs_ack_o = gnt_cyc & wbm_ack_i & ~wbm_err_i;
                iwbs_err_o = (gnt_cyc & wbm_err_i) | timeout;
            end
            StGntD: begin
                wbm_cyc_o  = d_req & ~timeout;
                wbm_stb_o  = d_req;
                wbm_we_o   = dwbs_we_i;
                wbm_sel_o  = dwbs_sel_i;
                wbm_addr_o = dwbs_addr_i;
                wbm_dat_o  = dwbs_dat_i;
                dwbs_ack_o = gnt_cyc & wbm_ack_i & ~wbm_err_i;
                dwbs_err_o = (gnt_cyc & wbm_err_i) | timeout;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Self-checking bench for core_bus_arbiter: a data-priority instance (p_*) and a
// round-robin instance (r_*) share the master-side inputs; each has its own slave.
module tb_core_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni = 1'b0;
    logic        i_cyc = 1'b0, i_stb = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_cyc = 1'b0, d_stb = 1'b0, d_we = 1'b0;
    logic [3:0]  d_sel = '0;
    logic [31:0] d_addr = '0, d_wdat = '0;

    logic        p_ack_in = 1'b0, p_err_in = 1'b0;
    logic [31:0] p_rdat = '0;
    logic [31:0] p_idat, p_ddat, p_wdat_o, p_addr_o;
    logic        p_iack, p_ierr, p_dack, p_derr, p_cyc, p_stb, p_we;
    logic [3:0]  p_sel;

    logic        r_ack_in = 1'b0, r_err_in = 1'b0;
    logic [31:0] r_rdat = '0;
    logic [31:0] r_idat, r_ddat, r_wdat_o, r_addr_o;
    logic        r_iack, r_ierr, r_dack, r_derr, r_cyc, r_stb, r_we;
    logic [3:0]  r_sel;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    core_bus_arbiter #(.TIMEOUT_CYCLES(8), .DATA_PRIORITY(1'b1)) dut_p (
        .clk_i(clk), .rst_ni(rst_ni),
        .iwbs_cyc_i(i_cyc), .iwbs_stb_i(i_stb), .iwbs_addr_i(i_addr),
        .iwbs_dat_o(p_idat), .iwbs_ack_o(p_iack), .iwbs_err_o(p_ierr),
        .dwbs_cyc_i(d_cyc), .dwbs_stb_i(d_stb), .dwbs_we_i(d_we), .dwbs_sel_i(d_sel),
        .dwbs_addr_i(d_addr), .dwbs_dat_i(d_wdat),
        .dwbs_dat_o(p_ddat), .dwbs_ack_o(p_dack), .dwbs_err_o(p_derr),
        .wbm_cyc_o(p_cyc), .wbm_stb_o(p_stb), .wbm_we_o(p_we), .wbm_sel_o(p_sel),
        .wbm_addr_o(p_addr_o), .wbm_dat_o(p_wdat_o),
        .wbm_dat_i(p_rdat), .wbm_ack_i(p_ack_in), .wbm_err_i(p_err_in)
    );

    core_bus_arbiter #(.TIMEOUT_CYCLES(8), .DATA_PRIORITY(1'b0)) dut_r (
        .clk_i(clk), .rst_ni(rst_ni),
        .iwbs_cyc_i(i_cyc), .iwbs_stb_i(i_stb), .iwbs_addr_i(i_addr),
        .iwbs_dat_o(r_idat), .iwbs_ack_o(r_iack), .iwbs_err_o(r_ierr),
        .dwbs_cyc_i(d_cyc), .dwbs_stb_i(d_stb), .dwbs_we_i(d_we), .dwbs_sel_i(d_sel),
        .dwbs_addr_i(d_addr), .dwbs_dat_i(d_wdat),
        .dwbs_dat_o(r_ddat), .dwbs_ack_o(r_dack), .dwbs_err_o(r_derr),
        .wbm_cyc_o(r_cyc), .wbm_stb_o(r_stb), .wbm_we_o(r_we), .wbm_sel_o(r_sel),
        .wbm_addr_o(r_addr_o), .wbm_dat_o(r_wdat_o),
        .wbm_dat_i(r_rdat), .wbm_ack_i(r_ack_in), .wbm_err_i(r_err_in)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0;
        p_ack_in = 1'b0; p_err_in = 1'b0; r_ack_in = 1'b0; r_err_in = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1;
        d_sel = 4'hF; d_addr = 32'h1234; d_wdat = 32'h5678; i_addr = 32'h9ABC;
        p_ack_in = 1'b1; r_ack_in = 1'b1;
        p_rdat = $urandom; r_rdat = $urandom;
        for (int k = 0; k < 2; k++) begin
            #1;
            total_cnt++;
            if ({p_cyc, p_stb, p_we, p_sel, p_addr_o, p_wdat_o} !== '0)
                $display("FAIL reset_bus_p: got cyc=%b stb=%b we=%b sel=%h addr=%h dat=%h, want all 0",
                         p_cyc, p_stb, p_we, p_sel, p_addr_o, p_wdat_o);
            else pass_cnt++;
            total_cnt++;
            if ({r_cyc, r_stb, r_we, r_sel, r_addr_o, r_wdat_o} !== '0)
                $display("FAIL reset_bus_r: got cyc=%b stb=%b, want all 0", r_cyc, r_stb);
            else pass_cnt++;
            total_cnt++;
            if ({p_iack, p_ierr, p_dack, p_derr, r_iack, r_ierr, r_dack, r_derr} !== 8'h0)
                $display("FAIL reset_resp: got %b, want 00000000",
                         {p_iack, p_ierr, p_dack, p_derr, r_iack, r_ierr, r_dack, r_derr});
            else pass_cnt++;
            total_cnt++;
            if (p_idat !== p_rdat || p_ddat !== p_rdat || r_idat !== r_rdat || r_ddat !== r_rdat)
                $display("FAIL reset_dat: got %h %h, want %h", p_idat, p_ddat, p_rdat);
            else pass_cnt++;
            step();
        end
        idle_inputs();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_single_fetch();
        do_reset();
        i_addr = 32'h8000_0000; i_cyc = 1'b1; i_stb = 1'b1;
        step();
        total_cnt++;
        if ({p_cyc, p_stb, p_we, p_sel, p_addr_o} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h8000_0000})
            $display("FAIL fetch_req: got cyc=%b stb=%b we=%b sel=%h addr=%h, want 1 1 0 f 80000000",
                     p_cyc, p_stb, p_we, p_sel, p_addr_o);
        else pass_cnt++;
        step();
        step();
        p_ack_in = 1'b1; p_rdat = 32'h0000_0013;
        #1;
        total_cnt++;
        if ({p_iack, p_ierr, p_dack, p_derr} !== 4'b1000 || p_idat !== 32'h13)
            $display("FAIL fetch_ack: got ack/err i=%b%b d=%b%b dat=%h, want i=10 d=00 dat=13",
                     p_iack, p_ierr, p_dack, p_derr, p_idat);
        else pass_cnt++;
        step();
        p_ack_in = 1'b0; i_cyc = 1'b0; i_stb = 1'b0;
        #1;
        total_cnt++;
        if (p_iack !== 1'b0 || p_cyc !== 1'b0)
            $display("FAIL fetch_done: got ack=%b cyc=%b, want 0 0", p_iack, p_cyc);
        else pass_cnt++;
    endtask

    task automatic test_tie_priority();
        do_reset();
        i_addr = 32'h0000_0200; i_cyc = 1'b1; i_stb = 1'b1;
        d_addr = 32'h100; d_wdat = 32'hDEAD_BEEF; d_sel = 4'b0011; d_we = 1'b1;
        d_cyc = 1'b1; d_stb = 1'b1;
        step();
        total_cnt++;
        if ({p_stb, p_we, p_sel, p_addr_o, p_wdat_o} !==
            {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF})
            $display("FAIL tie_d_first: got stb=%b we=%b sel=%b addr=%h dat=%h, want 1 1 0011 100 deadbeef",
                     p_stb, p_we, p_sel, p_addr_o, p_wdat_o);
        else pass_cnt++;
        p_ack_in = 1'b1;
        #1;
        total_cnt++;
        if ({p_dack, p_iack} !== 2'b10)
            $display("FAIL tie_d_ack: got d=%b i=%b, want d=1 i=0", p_dack, p_iack);
        else pass_cnt++;
        step();
        p_ack_in = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0;
        #1;
        total_cnt++;
        if (p_cyc !== 1'b0 || p_stb !== 1'b0)
            $display("FAIL tie_idle_gap: got cyc=%b stb=%b, want 0 0", p_cyc, p_stb);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({p_stb, p_we, p_sel, p_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h200})
            $display("FAIL tie_i_second: got stb=%b we=%b sel=%h addr=%h, want 1 0 f 200",
                     p_stb, p_we, p_sel, p_addr_o);
        else pass_cnt++;
        p_ack_in = 1'b1;
        #1;
        total_cnt++;
        if ({p_iack, p_dack} !== 2'b10)
            $display("FAIL tie_i_ack: got i=%b d=%b, want i=1 d=0", p_iack, p_dack);
        else pass_cnt++;
        step();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic want_d;
        do_reset();
        i_addr = 32'hAAAA_0000; d_addr = 32'hDDDD_0000;
        i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
        for (int n = 0; n < 4; n++) begin
            want_d = (n % 2 == 0);
            step();
            total_cnt++;
            if (r_stb !== 1'b1 || r_addr_o !== (want_d ? d_addr : i_addr))
                $display("FAIL rr_grant%0d: got stb=%b addr=%h, want 1 %h",
                         n, r_stb, r_addr_o, want_d ? d_addr : i_addr);
            else pass_cnt++;
            r_ack_in = 1'b1;
            #1;
            total_cnt++;
            if ({r_dack, r_iack} !== {want_d, !want_d})
                $display("FAIL rr_ack%0d: got d=%b i=%b, want d=%b i=%b",
                         n, r_dack, r_iack, want_d, !want_d);
            else pass_cnt++;
            step();
            r_ack_in = 1'b0;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_watchdog();
        do_reset();
        i_addr = 32'h0000_0040; i_cyc = 1'b1; i_stb = 1'b1;
        d_addr = 32'h0000_0080; d_cyc = 1'b1; d_stb = 1'b1;
        step();
        for (int c = 1; c < 8; c++) begin
            total_cnt++;
            if (p_derr !== 1'b0 || p_cyc !== 1'b1)
                $display("FAIL wd_wait%0d: got err=%b cyc=%b, want 0 1", c, p_derr, p_cyc);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if ({p_derr, p_dack, p_cyc, p_iack, p_ierr} !== 5'b10000)
            $display("FAIL wd_fire: got err=%b ack=%b cyc=%b iack=%b ierr=%b, want 1 0 0 0 0",
                     p_derr, p_dack, p_cyc, p_iack, p_ierr);
        else pass_cnt++;
        step();
        d_cyc = 1'b0; d_stb = 1'b0;
        #1;
        total_cnt++;
        if (p_cyc !== 1'b0 || p_derr !== 1'b0)
            $display("FAIL wd_idle: got cyc=%b err=%b, want 0 0", p_cyc, p_derr);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({p_cyc, p_stb, p_addr_o} !== {1'b1, 1'b1, 32'h40})
            $display("FAIL wd_queued_fetch: got cyc=%b stb=%b addr=%h, want 1 1 40",
                     p_cyc, p_stb, p_addr_o);
        else pass_cnt++;
        p_ack_in = 1'b1;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_timeout_ack();
        do_reset();
        d_addr = 32'h0000_0300; d_cyc = 1'b1; d_stb = 1'b1;
        step();
        repeat (7) step();
        p_ack_in = 1'b1;
        #1;
        total_cnt++;
        if ({p_dack, p_derr, p_cyc} !== 3'b101)
            $display("FAIL to_ack_wins: got ack=%b err=%b cyc=%b, want 1 0 1", p_dack, p_derr, p_cyc);
        else pass_cnt++;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_err_priority();
        do_reset();
        d_addr = 32'h0000_0400; d_cyc = 1'b1; d_stb = 1'b1;
        step();
        p_ack_in = 1'b1; p_err_in = 1'b1;
        #1;
        total_cnt++;
        if ({p_derr, p_dack, p_iack, p_ierr} !== 4'b1000)
            $display("FAIL err_prio: got err=%b ack=%b iack=%b ierr=%b, want 1 0 0 0",
                     p_derr, p_dack, p_iack, p_ierr);
        else pass_cnt++;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_abort_reset();
        do_reset();
        d_addr = 32'h0000_0500; d_cyc = 1'b1; d_stb = 1'b1;
        step();
        step();
        d_cyc = 1'b0;
        p_ack_in = 1'b1;
        #1;
        total_cnt++;
        if ({p_dack, p_derr, p_iack, p_ierr} !== 4'b0000)
            $display("FAIL abort_resp: got %b, want 0000", {p_dack, p_derr, p_iack, p_ierr});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({p_dack, p_derr, p_cyc} !== 3'b000)
            $display("FAIL abort_late_ack: got ack=%b err=%b cyc=%b, want 0 0 0",
                     p_dack, p_derr, p_cyc);
        else pass_cnt++;
        p_ack_in = 1'b0; d_stb = 1'b0;
        i_addr = 32'h0000_0600; i_cyc = 1'b1; i_stb = 1'b1;
        step();
        total_cnt++;
        if (p_stb !== 1'b1)
            $display("FAIL abort_igrant: got stb=%b, want 1", p_stb);
        else pass_cnt++;
        rst_ni = 1'b0;
        p_ack_in = 1'b1;
        #1;
        total_cnt++;
        if ({p_cyc, p_stb, p_we, p_sel, p_addr_o, p_wdat_o} !== '0 ||
            {p_iack, p_ierr, p_dack, p_derr} !== 4'b0000)
            $display("FAIL midreset: got cyc=%b stb=%b addr=%h iack=%b ierr=%b, want all 0",
                     p_cyc, p_stb, p_addr_o, p_iack, p_ierr);
        else pass_cnt++;
        idle_inputs();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    // Random transactions on the round-robin instance; the model only tracks who
    // was granted last and applies the tie rule.
    task automatic test_random();
        logic        last_d;
        logic        want_d, exp_ack, exp_err, exp_we;
        logic [1:0]  who;
        logic [3:0]  exp_sel;
        logic [31:0] exp_addr, rd;
        int unsigned lat, kind;
        do_reset();
        last_d = 1'b0;
        for (int n = 0; n < 40; n++) begin
            who = 2'($urandom_range(1, 3));
            i_addr = $urandom; d_addr = $urandom; d_wdat = $urandom;
            d_we = 1'($urandom); d_sel = 4'($urandom);
            i_cyc = who[0]; i_stb = who[0]; d_cyc = who[1]; d_stb = who[1];
            want_d = (who == 2'b11) ? !last_d : who[1];
            last_d = want_d;
            exp_addr = want_d ? d_addr : i_addr;
            exp_we = want_d ? d_we : 1'b0;
            exp_sel = want_d ? d_sel : 4'hF;
            step();
            total_cnt++;
            if ({r_cyc, r_stb, r_we, r_sel, r_addr_o} !== {1'b1, 1'b1, exp_we, exp_sel, exp_addr} ||
                (want_d && r_wdat_o !== d_wdat))
                $display("FAIL rand_req%0d: got we=%b sel=%h addr=%h dat=%h, want %b %h %h (data port=%b)",
                         n, r_we, r_sel, r_addr_o, r_wdat_o, exp_we, exp_sel, exp_addr, want_d);
            else pass_cnt++;
            lat = $urandom_range(0, 3);
            repeat (lat) begin
                total_cnt++;
                if ({r_iack, r_ierr, r_dack, r_derr} !== 4'b0000)
                    $display("FAIL rand_wait%0d: got %b, want 0000", n, {r_iack, r_ierr, r_dack, r_derr});
                else pass_cnt++;
                step();
            end
            kind = $urandom_range(0, 3);
            rd = $urandom;
            exp_ack = (kind < 2);
            exp_err = (kind >= 2);
            r_rdat = rd; r_ack_in = (kind != 2); r_err_in = (kind >= 2);
            #1;
            total_cnt++;
            if ((want_d && {r_dack, r_derr, r_iack, r_ierr} !== {exp_ack, exp_err, 2'b00}) ||
                (!want_d && {r_iack, r_ierr, r_dack, r_derr} !== {exp_ack, exp_err, 2'b00}))
                $display("FAIL rand_resp%0d: got i=%b%b d=%b%b, want ack=%b err=%b on data port=%b",
                         n, r_iack, r_ierr, r_dack, r_derr, exp_ack, exp_err, want_d);
            else pass_cnt++;
            total_cnt++;
            if (r_idat !== rd || r_ddat !== rd)
                $display("FAIL rand_dat%0d: got %h %h, want %h", n, r_idat, r_ddat, rd);
            else pass_cnt++;
            step();
            idle_inputs();
            #1;
            total_cnt++;
            if (r_cyc !== 1'b0)
                $display("FAIL rand_idle%0d: got cyc=%b, want 0", n, r_cyc);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_tie_priority();
        test_round_robin();
        test_watchdog();
        test_timeout_ack();
        test_err_priority();
        test_abort_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, want completion");
        $fatal(1, "simulation time limit");
    end

endmodule
